// File: rtl/md_unit_if.sv
// md_unit_if: E-stage request/response bundle for the multiply/divide unit.
// The pipeline (master) drives the operation request and HI/LO select; the
// md_unit (slave) returns busy, the selected HI/LO value and both registers.
interface md_unit_if;
   logic        start;
   logic [3:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        req;
   logic        hilo_sel;
   logic        busy;
   logic [31:0] out;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output start, op, A, B, req, hilo_sel,
      input  busy, out, HI, LO
   );

   modport slave (
      input  start, op, A, B, req, hilo_sel,
      output busy, out, HI, LO
   );
endinterface

// File: rtl/md_unit.sv
// md_unit: MIPS E-stage multiply/divide unit owning the HI/LO registers.
// Executes mult/multu/div/divu with fixed latencies and mthi/mtlo as
// single-cycle writes. Optional feature macro: MD_UNIT_MACC_EN enables
// madd/maddu/msub/msubu (op codes 7..10); without it those codes are ignored.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   md_unit_if.slave   md
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t      state_q;
   logic [3:0]  count_q;
   logic [3:0]  op_q;
   logic [31:0] opA_q;
   logic [31:0] opB_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        busy_q;

   logic        isMul;
   logic        isDiv;
   logic        isMacc;
   logic        issue;
   logic        mtWrite;

   logic signed [63:0] prodS;
   logic [63:0]        prodU;
   logic               divSigned;
   logic [31:0]        numMag;
   logic [31:0]        denMag;
   logic [31:0]        quoMag;
   logic [31:0]        remMag;
   logic [31:0]        quo;
   logic [31:0]        rem;
   logic [63:0]        hiLo_d;
   logic               resWe;

   // Decode the incoming op and decide whether it issues or writes HI/LO now
   always_comb begin
      isMul   = (md.op == 4'd1) || (md.op == 4'd2);
      isDiv   = (md.op == 4'd3) || (md.op == 4'd4);
`ifdef MD_UNIT_MACC_EN
      isMacc  = (md.op >= 4'd7) && (md.op <= 4'd10);
`else
      isMacc  = 1'b0;
`endif
      issue   = md.start && (state_q == IDLE) && !md.req && (isMul || isDiv || isMacc);
      mtWrite = (state_q == IDLE) && !md.req && ((md.op == 4'd5) || (md.op == 4'd6));
   end

   // Compute the result of the latched op from the latched operands and the
   // current HI/LO, which is what gets committed on the final RUN cycle
   always_comb begin
      prodS     = $signed({{32{opA_q[31]}}, opA_q}) * $signed({{32{opB_q[31]}}, opB_q});
      prodU     = {32'd0, opA_q} * {32'd0, opB_q};
      divSigned = (op_q == 4'd3);
      numMag    = (divSigned && opA_q[31]) ? -opA_q : opA_q;
      denMag    = (divSigned && opB_q[31]) ? -opB_q : opB_q;
      quoMag    = (denMag == 32'd0) ? 32'd0 : (numMag / denMag);
      remMag    = (denMag == 32'd0) ? 32'd0 : (numMag % denMag);
      quo       = (divSigned && (opA_q[31] ^ opB_q[31])) ? -quoMag : quoMag;
      rem       = (divSigned && opA_q[31]) ? -remMag : remMag;
      hiLo_d    = {hi_q, lo_q};
      resWe     = 1'b1;
      case (op_q)
         4'd1: hiLo_d = $unsigned(prodS);
         4'd2: hiLo_d = prodU;
         4'd3, 4'd4: begin
            if (opB_q == 32'd0) resWe = 1'b0;
            else                hiLo_d = {rem, quo};
         end
`ifdef MD_UNIT_MACC_EN
         4'd7:  hiLo_d = {hi_q, lo_q} + $unsigned(prodS);
         4'd8:  hiLo_d = {hi_q, lo_q} + prodU;
         4'd9:  hiLo_d = {hi_q, lo_q} - $unsigned(prodS);
         4'd10: hiLo_d = {hi_q, lo_q} - prodU;
`endif
         default: resWe = 1'b0;
      endcase
   end

   // Issue/countdown FSM with registered busy; HI/LO written on the last RUN cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= 4'd0;
         op_q    <= 4'd0;
         opA_q   <= 32'd0;
         opB_q   <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
      end else if (state_q == IDLE) begin
         if (issue) begin
            op_q    <= md.op;
            opA_q   <= md.A;
            opB_q   <= md.B;
            count_q <= isDiv ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= RUN;
         end else if (mtWrite) begin
            if (md.op == 4'd5) hi_q <= md.A;
            else               lo_q <= md.A;
         end
      end else begin
         if (count_q == 4'd1) begin
            if (resWe) begin
               hi_q <= hiLo_d[63:32];
               lo_q <= hiLo_d[31:0];
            end
            count_q <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
         end else begin
            count_q <= count_q - 4'd1;
         end
      end
   end

   // Drive the registered outputs and the zero-latency HI/LO select
   always_comb begin
      md.busy = busy_q;
      md.HI   = hi_q;
      md.LO   = lo_q;
      md.out  = md.hilo_sel ? hi_q : lo_q;
   end

endmodule
